// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   rx_state_t        receiver FSM state encoding
//   END_WORD_DEFAULT  terminator word that ends a program load
//   BYTES_PER_WORD    bytes packed little-endian into each memory word
package uart_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;
    localparam int          BYTES_PER_WORD   = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk, rst    system clock, synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   enable      when low the receiver is parked in IDLE and ignores rx
//   byte_valid  one-cycle strobe: good stop bit seen, byte_data is complete
//   byte_data   received byte, LSB first on the wire
//   stop_err    one-cycle strobe: stop bit sampled low, byte discarded
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       enable,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             tick;

    // START waits half a bit to land in the middle of the start bit; every
    // later sample is a whole bit after the previous one.
    assign tick = (state == START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

    // Decoded straight from the stop-bit sample so the top level can register
    // its write strobe on the following cycle.
    assign byte_valid = enable && (state == STOP) && tick &&  rx_sync;
    assign stop_err   = enable && (state == STOP) && tick && !rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_data <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (rx_prev && !rx_sync)
                            state <= START;
                    end
                    START: begin
                        if (tick) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            // line back high at mid-start-bit means a glitch
                            state   <= rx_sync ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            cnt       <= '0;
                            byte_data <= {rx_sync, byte_data[7:1]};
                            bit_idx   <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7)
                                state <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes, packs them little-endian into
// 32-bit words and writes them to sequential instruction-memory addresses.
// The core is held in reset until the terminator word arrives.
//   wb_clk_i, wb_rst_i  system clock, synchronous active-high reset
//   rx_i                UART serial input
//   ready_o             loader armed and accepting bytes
//   mem_we_o            one-cycle write strobe
//   mem_addr_o          word address (wraps silently)
//   mem_wdata_o         write data
//   done_o              terminator received (sticky)
//   core_rst_o          active-high core reset, released on done
//   frame_err_o         bad stop bit seen (sticky)
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_W       = 14,
    parameter logic [31:0] END_WORD     = END_WORD_DEFAULT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_i,
    output logic              ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              done_o,
    output logic              core_rst_o,
    output logic              frame_err_o
);

    logic        byte_valid;
    logic        stop_err;
    logic [7:0]  byte_data;
    logic [1:0]  byte_idx;
    logic [23:0] word_lo;
    logic [31:0] word_full;

    // Once done, the receiver is frozen so later line activity is ignored.
    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .rx         (rx_i),
        .enable     (!done_o),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err)
    );

    // Byte 3 is taken straight from the receiver so the word is complete
    // on the same cycle its last byte is validated.
    assign word_full = {byte_data, word_lo};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ready_o     <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            done_o      <= 1'b0;
            core_rst_o  <= 1'b1;
            frame_err_o <= 1'b0;
            byte_idx    <= '0;
            word_lo     <= '0;
        end else begin
            mem_we_o <= 1'b0;
            ready_o  <= !done_o;
            if (mem_we_o)
                mem_addr_o <= mem_addr_o + 1'b1;
            if (stop_err)
                frame_err_o <= 1'b1;
            if (byte_valid) begin
                byte_idx <= byte_idx + 1'b1;
                case (byte_idx)
                    2'd0: word_lo[7:0]   <= byte_data;
                    2'd1: word_lo[15:8]  <= byte_data;
                    2'd2: word_lo[23:16] <= byte_data;
                    default: begin
                        if (word_full == END_WORD) begin
                            done_o     <= 1'b1;
                            ready_o    <= 1'b0;
                            core_rst_o <= 1'b0;
                        end else begin
                            mem_we_o    <= 1'b1;
                            mem_wdata_o <= word_full;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

    localparam int          CPB  = 16;
    localparam int          AW   = 3;
    localparam logic [31:0] ENDW = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          ready_o, mem_we_o, done_o, core_rst_o, frame_err_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .END_WORD     (ENDW)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .rx_i        (rx),
        .ready_o     (ready_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .done_o      (done_o),
        .core_rst_o  (core_rst_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: bytes collected so far, next address, done flag
    logic [7:0]    m_bytes[$];
    int            m_addr;
    bit            m_done;
    logic [AW-1:0] exp_a[$], obs_a[$];
    logic [31:0]   exp_d[$], obs_d[$];

    always @(negedge clk)
        if (mem_we_o) begin
            obs_a.push_back(mem_addr_o);
            obs_d.push_back(mem_wdata_o);
        end

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] w;
        if (m_done) return;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_bytes.delete();
            if (w == ENDW) m_done = 1;
            else begin
                exp_a.push_back(AW'(m_addr));
                exp_d.push_back(w);
                m_addr = (m_addr + 1) % (1 << AW);
            end
        end
    endtask

    // called and returns at a falling edge; good frames chain back-to-back
    task automatic uart_frame(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!good_stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        uart_frame(b, good_stop);
        if (good_stop) model_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == ENDW) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        m_bytes.delete(); exp_a.delete(); exp_d.delete();
        obs_a.delete(); obs_d.delete();
        m_addr = 0; m_done = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({ready_o, mem_we_o, done_o, core_rst_o, frame_err_o} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_flags: got rdy/we/done/crst/ferr=%b want 00010",
                     {ready_o, mem_we_o, done_o, core_rst_o, frame_err_o});
        end
        checks++;
        if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%0h data=%h want 0/0", mem_addr_o, mem_wdata_o);
        end
        rx  = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", ready_o);
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b want 1", ready_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_word(32'h0000_0013);
        send_word(ENDW);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_a.size() != 1 || obs_a[0] !== 0 || obs_d[0] !== 32'h13) begin
            errors++;
            $display("FAIL basic_write: got n=%0d addr=%0h data=%h want 1 write 0/00000013",
                     obs_a.size(), obs_a.size() ? obs_a[0] : '0, obs_d.size() ? obs_d[0] : '0);
        end
        checks++;
        if ({done_o, core_rst_o, ready_o} !== {m_done, 2'b00}) begin
            errors++;
            $display("FAIL basic_done: got done/crst/rdy=%b want %b",
                     {done_o, core_rst_o, ready_o}, {m_done, 2'b00});
        end
    endtask

    task automatic test_after_done();
        logic [AW-1:0] a0;
        a0 = mem_addr_o;
        send_word(rand_word());
        send_byte(8'($urandom), 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_a.size() != 1 || mem_addr_o !== a0 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL after_done: got writes=%0d addr=%0h done=%b want 1/%0h/1",
                     obs_a.size(), mem_addr_o, done_o, a0);
        end
    endtask

    task automatic test_three_words();
        do_reset();
        send_word(32'h0000_0513);
        send_word(32'h00A0_0593);
        send_word(32'hDEAD_BEEF);
        send_word(ENDW);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_a.size() != 3 || exp_a.size() != 3) begin
            errors++;
            $display("FAIL three_count: got %0d writes want 3", obs_a.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL three_word%0d: got %0h/%h want %0h/%h",
                             i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (frame_err_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_flag: got %b want 1", frame_err_o);
        end
        checks++;
        if (obs_a.size() != 1 || obs_a[0] !== 0 || obs_d[0] !== 32'h4433_2211) begin
            errors++;
            $display("FAIL frame_err_word: got n=%0d data=%h want 1 write 44332211",
                     obs_a.size(), obs_d.size() ? obs_d[0] : '0);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] w;
        do_reset();
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (obs_a.size() != 0 || frame_err_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL glitch_quiet: got writes=%0d ferr=%b rdy=%b want 0/0/1",
                     obs_a.size(), frame_err_o, ready_o);
        end
        w = rand_word();
        send_word(w);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_d.size() != 1 || obs_d[0] !== w || obs_a[0] !== 0) begin
            errors++;
            $display("FAIL glitch_next_word: got n=%0d data=%h want 1 write %h",
                     obs_d.size(), obs_d.size() ? obs_d[0] : '0, w);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_word(rand_word());
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        // drop reset in the middle of the third byte's data bits
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready_o, mem_we_o, done_o, core_rst_o, frame_err_o} !== 5'b00010 ||
            mem_addr_o !== '0 || mem_wdata_o !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags=%b addr=%0h data=%h want 00010/0/0",
                     {ready_o, mem_we_o, done_o, core_rst_o, frame_err_o}, mem_addr_o, mem_wdata_o);
        end
        do_reset();
        send_word(rand_word());
        send_word(rand_word());
        send_word(ENDW);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_a.size() != exp_a.size()) begin
            errors++;
            $display("FAIL reload_count: got %0d want %0d", obs_a.size(), exp_a.size());
        end else begin
            for (int i = 0; i < exp_a.size(); i++) begin
                checks++;
                if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL reload_word%0d: got %0h/%h want %0h/%h",
                             i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) send_word(rand_word());
        send_word(ENDW);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_a.size() != exp_a.size() || exp_a.size() != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 10", obs_a.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %0h/%h want %0h/%h",
                             i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
                end
            end
        end
        checks++;
        if ({done_o, core_rst_o, ready_o, frame_err_o} !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_done: got done/crst/rdy/ferr=%b want 1000",
                     {done_o, core_rst_o, ready_o, frame_err_o});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_after_done();
        test_three_words();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
